// File: rtl/frame_fifo_fwft.sv
// Frame-oriented FIFO with first-word-fall-through read side. Words become
// visible to the reader only once committed; uncommitted words can be discarded.
`timescale 1ns/1ps

module frame_fifo_fwft #(
   parameter int DATA_WIDTH   = 9,
   parameter int ADDR_WIDTH   = 10,
   parameter int AFULL_LEVEL  = 1008,
   parameter int AEMPTY_LEVEL = 16
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  WE,
   input  logic [DATA_WIDTH-1:0] WD,
   input  logic                  WCOMMIT,
   input  logic                  WDISCARD,
   output logic                  FULL,
   output logic                  AFULL,
   input  logic                  RE,
   output logic [DATA_WIDTH-1:0] RD,
   output logic                  RVALID,
   output logic                  EMPTY,
   output logic                  AEMPTY,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int                DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_ram_q;
   logic [DATA_WIDTH-1:0] r_rd;
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_commit_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic                  r_q_valid;
   logic                  r_rvalid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic [ADDR_WIDTH:0]   w_occupancy;
   logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   w_count;
   logic                  w_full;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_advance;
   logic                  w_pop;

   // Occupancy counts every word still held in the RAM, committed or not.
   assign w_occupancy  = r_wr_ptr - r_rd_ptr;
   assign w_full       = (w_occupancy == LP_DEPTH);
   assign w_wr_en      = RESET_N & WE & ~w_full & ~WDISCARD;
   assign w_wr_ptr_nxt = w_wr_en ? r_wr_ptr + 1'b1 : r_wr_ptr;

   // Two read stages: RAM output register (r_ram_q) then the RD register.
   // A stage-1 word moves to RD whenever RD is empty or being popped.
   assign w_pop     = RE & r_rvalid;
   assign w_advance = r_q_valid & (~r_rvalid | RE);
   assign w_rd_en   = RESET_N & (r_rd_ptr != r_commit_ptr) & (~r_q_valid | w_advance);

   assign w_count = (r_commit_ptr - r_rd_ptr)
                  + {{ADDR_WIDTH{1'b0}}, r_rvalid}
                  + {{ADDR_WIDTH{1'b0}}, r_q_valid};

   // NOTE: the RAM array and its read register carry no reset so they map onto
   // block RAM; RESET_N instead gates the write and read enables.
   always_ff @(posedge CLK) begin
      if (w_wr_en) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= WD;
      if (w_rd_en) r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
      end else if (WDISCARD) begin
         r_wr_ptr <= r_commit_ptr;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         if (WCOMMIT) r_commit_ptr <= w_wr_ptr_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rd_ptr  <= '0;
         r_q_valid <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rd      <= '0;
      end else begin
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;

         if (w_rd_en)        r_q_valid <= 1'b1;
         else if (w_advance) r_q_valid <= 1'b0;

         if (w_advance) begin
            r_rvalid <= 1'b1;
            r_rd     <= r_ram_q;
         end else if (w_pop) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (WE && w_full)    r_overflow  <= 1'b1;
         if (RE && !r_rvalid) r_underflow <= 1'b1;
      end
   end

   assign FULL      = w_full;
   assign AFULL     = (w_occupancy >= LP_AFULL);
   assign RD        = r_rd;
   assign RVALID    = r_rvalid;
   assign EMPTY     = ~r_rvalid;
   assign COUNT     = w_count;
   assign AEMPTY    = (w_count <= LP_AEMPTY);
   assign OVERFLOW  = r_overflow;
   assign UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_frame_fifo_fwft.sv
// Directed bench for frame_fifo_fwft: commit/discard, fall-through latency,
// full/overflow, sustained streaming across pointer wrap, underflow and reset.
`timescale 1ns/1ps

module tb_frame_fifo_fwft;

   localparam int DW = 9;
   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          WE = 1'b0;
   logic [DW-1:0] WD = '0;
   logic          WCOMMIT = 1'b0;
   logic          WDISCARD = 1'b0;
   logic          RE = 1'b0;
   logic          FULL, AFULL, RVALID, EMPTY, AEMPTY, OVERFLOW, UNDERFLOW;
   logic [DW-1:0] RD;
   logic [AW:0]   COUNT;

   int total = 0;
   int bad   = 0;

   frame_fifo_fwft #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(1008), .AEMPTY_LEVEL(16)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .WD(WD), .WCOMMIT(WCOMMIT),
      .WDISCARD(WDISCARD), .FULL(FULL), .AFULL(AFULL), .RE(RE), .RD(RD),
      .RVALID(RVALID), .EMPTY(EMPTY), .AEMPTY(AEMPTY), .COUNT(COUNT),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] pat(input int i);
      return DW'((i * 37 + 5) & 511);
   endfunction

   // Inputs change 1 ns after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_rvalid(input string tag);
      int n;
      n = 0;
      while (RVALID !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (RVALID !== 1'b1) begin
         bad++;
         $display("FAIL %s_wait_rvalid got=%b want=1 after %0d cycles", tag, RVALID, n);
      end
   endtask

   task automatic test_reset(input string tag);
      WE = 0; WCOMMIT = 0; WDISCARD = 0; RE = 0;
      #2 RESET_N = 1'b0;
      idle(2);
      total++; if (RVALID !== 1'b0)    begin bad++; $display("FAIL %s_rvalid got=%b want=0", tag, RVALID); end
      total++; if (EMPTY !== 1'b1)     begin bad++; $display("FAIL %s_empty got=%b want=1", tag, EMPTY); end
      total++; if (RD !== 9'h000)      begin bad++; $display("FAIL %s_rd got=%h want=000", tag, RD); end
      total++; if (FULL !== 1'b0)      begin bad++; $display("FAIL %s_full got=%b want=0", tag, FULL); end
      total++; if (AFULL !== 1'b0)     begin bad++; $display("FAIL %s_afull got=%b want=0", tag, AFULL); end
      total++; if (COUNT !== 11'd0)    begin bad++; $display("FAIL %s_count got=%0d want=0", tag, COUNT); end
      total++; if (AEMPTY !== 1'b1)    begin bad++; $display("FAIL %s_aempty got=%b want=1", tag, AEMPTY); end
      total++; if (OVERFLOW !== 1'b0)  begin bad++; $display("FAIL %s_overflow got=%b want=0", tag, OVERFLOW); end
      total++; if (UNDERFLOW !== 1'b0) begin bad++; $display("FAIL %s_underflow got=%b want=0", tag, UNDERFLOW); end
      RESET_N = 1'b1;
      idle(2);
   endtask

   task automatic test_single_word();
      WE = 1; WD = 9'h1A5; WCOMMIT = 1;
      step();
      WE = 0; WCOMMIT = 0;
      total++; if (RVALID !== 1'b0) begin bad++; $display("FAIL single_early_rvalid got=%b want=0", RVALID); end
      step();
      total++; if (RVALID !== 1'b0) begin bad++; $display("FAIL single_edge1_rvalid got=%b want=0", RVALID); end
      step();
      total++; if (RVALID !== 1'b1)  begin bad++; $display("FAIL single_rvalid got=%b want=1", RVALID); end
      total++; if (RD !== 9'h1A5)    begin bad++; $display("FAIL single_rd got=%h want=1a5", RD); end
      total++; if (COUNT !== 11'd1)  begin bad++; $display("FAIL single_count got=%0d want=1", COUNT); end
      total++; if (AEMPTY !== 1'b1)  begin bad++; $display("FAIL single_aempty got=%b want=1", AEMPTY); end
      RE = 1;
      step();
      RE = 0;
      total++; if (EMPTY !== 1'b1)   begin bad++; $display("FAIL single_pop_empty got=%b want=1", EMPTY); end
      total++; if (COUNT !== 11'd0)  begin bad++; $display("FAIL single_pop_count got=%0d want=0", COUNT); end
   endtask

   task automatic test_discard();
      logic [DW-1:0] frame [3];
      frame[0] = 9'h011; frame[1] = 9'h022; frame[2] = 9'h033;
      for (int i = 0; i < 5; i++) begin
         WE = 1; WD = DW'(9'h100 + i);
         step();
      end
      WE = 0; WDISCARD = 1;
      step();
      WDISCARD = 0;
      idle(3);
      total++; if (RVALID !== 1'b0)  begin bad++; $display("FAIL discard_rvalid got=%b want=0", RVALID); end
      total++; if (COUNT !== 11'd0)  begin bad++; $display("FAIL discard_count got=%0d want=0", COUNT); end
      total++; if (FULL !== 1'b0)    begin bad++; $display("FAIL discard_full got=%b want=0", FULL); end
      for (int i = 0; i < 3; i++) begin
         WE = 1; WD = frame[i]; WCOMMIT = (i == 2);
         step();
      end
      WE = 0; WCOMMIT = 0;
      wait_rvalid("discard");
      total++; if (COUNT !== 11'd3) begin bad++; $display("FAIL discard_frame_count got=%0d want=3", COUNT); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (RVALID !== 1'b1 || RD !== frame[i]) begin
            bad++; $display("FAIL discard_frame_word%0d got=%b/%h want=1/%h", i, RVALID, RD, frame[i]);
         end
         RE = 1;
         step();
      end
      RE = 0;
      total++; if (RVALID !== 1'b0 || COUNT !== 11'd0) begin
         bad++; $display("FAIL discard_drained got=%b/%0d want=0/0", RVALID, COUNT);
      end
   endtask

   task automatic test_commit_discard();
      WE = 1; WD = 9'h055; WCOMMIT = 1;
      step();
      WCOMMIT = 0; WD = 9'h0BB;
      step();
      WD = 9'h0CC;
      step();
      WD = 9'h0EE; WCOMMIT = 1; WDISCARD = 1;
      step();
      WE = 0; WCOMMIT = 0; WDISCARD = 0;
      idle(4);
      total++; if (COUNT !== 11'd1) begin bad++; $display("FAIL cd_count got=%0d want=1", COUNT); end
      total++; if (RVALID !== 1'b1 || RD !== 9'h055) begin
         bad++; $display("FAIL cd_word got=%b/%h want=1/055", RVALID, RD);
      end
      RE = 1;
      step();
      RE = 0;
      idle(3);
      total++; if (RVALID !== 1'b0 || COUNT !== 11'd0) begin
         bad++; $display("FAIL cd_dropped got=%b/%0d want=0/0", RVALID, COUNT);
      end
      WE = 1; WD = 9'h077; WCOMMIT = 1;
      step();
      WE = 0; WCOMMIT = 0;
      wait_rvalid("cd_next");
      total++; if (RD !== 9'h077 || COUNT !== 11'd1) begin
         bad++; $display("FAIL cd_next_word got=%h/%0d want=077/1", RD, COUNT);
      end
      RE = 1;
      step();
      RE = 0;
   endtask

   task automatic test_back_to_back();
      fork
         begin
            for (int i = 0; i < 3000; i++) begin
               WE = 1; WD = pat(i); WCOMMIT = 1;
               step();
            end
            WE = 0; WCOMMIT = 0;
         end
         begin
            wait_rvalid("b2b");
            for (int k = 0; k < 3000; k++) begin
               total++;
               if (RVALID !== 1'b1 || RD !== pat(k)) begin
                  bad++; $display("FAIL b2b_word%0d got=%b/%h want=1/%h", k, RVALID, RD, pat(k));
               end
               RE = 1;
               step();
            end
            RE = 0;
         end
      join
      idle(3);
      total++; if (RVALID !== 1'b0 || COUNT !== 11'd0) begin
         bad++; $display("FAIL b2b_drained got=%b/%0d want=0/0", RVALID, COUNT);
      end
      total++; if (UNDERFLOW !== 1'b0) begin bad++; $display("FAIL b2b_underflow got=%b want=0", UNDERFLOW); end
   endtask

   task automatic test_full();
      total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL full_pre_overflow got=%b want=0", OVERFLOW); end
      for (int i = 0; i < 1024; i++) begin
         WE = 1; WD = pat(i + 5000); WCOMMIT = (i == 1023);
         step();
         total++;
         if (AFULL !== (i + 1 >= 1008) || FULL !== (i == 1023)) begin
            bad++; $display("FAIL full_write%0d afull/full got=%b/%b want=%b/%b",
                            i, AFULL, FULL, (i + 1 >= 1008), (i == 1023));
         end
      end
      WD = 9'h0AA; WCOMMIT = 0;
      step();
      WE = 0;
      total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b want=1", OVERFLOW); end
      total++; if (FULL !== 1'b0)     begin bad++; $display("FAIL full_after_pop got=%b want=0", FULL); end
      total++; if (COUNT !== 11'd1024) begin bad++; $display("FAIL full_count got=%0d want=1024", COUNT); end
      total++; if (AEMPTY !== 1'b0)   begin bad++; $display("FAIL full_aempty got=%b want=0", AEMPTY); end
      wait_rvalid("full");
      for (int k = 0; k < 1024; k++) begin
         total++;
         if (RVALID !== 1'b1 || RD !== pat(k + 5000)) begin
            bad++; $display("FAIL full_read%0d got=%b/%h want=1/%h", k, RVALID, RD, pat(k + 5000));
         end
         RE = 1;
         step();
      end
      RE = 0;
      idle(3);
      total++; if (RVALID !== 1'b0 || COUNT !== 11'd0) begin
         bad++; $display("FAIL full_drained got=%b/%0d want=0/0", RVALID, COUNT);
      end
      total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL full_overflow_sticky got=%b want=1", OVERFLOW); end
   endtask

   task automatic test_underflow_reset();
      total++; if (UNDERFLOW !== 1'b0) begin bad++; $display("FAIL uf_pre got=%b want=0", UNDERFLOW); end
      RE = 1;
      step();
      RE = 0;
      total++; if (UNDERFLOW !== 1'b1) begin bad++; $display("FAIL uf_set got=%b want=1", UNDERFLOW); end
      idle(3);
      total++; if (UNDERFLOW !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", UNDERFLOW); end
      total++; if (COUNT !== 11'd0 || RVALID !== 1'b0) begin
         bad++; $display("FAIL uf_no_effect got=%0d/%b want=0/0", COUNT, RVALID);
      end
      WE = 1; WD = 9'h101; WCOMMIT = 1;
      step();
      WD = 9'h102;
      step();
      WD = 9'h103; WCOMMIT = 0;
      step();
      test_reset("mid_reset");
      idle(3);
      total++; if (RVALID !== 1'b0 || COUNT !== 11'd0) begin
         bad++; $display("FAIL mid_reset_lost got=%b/%0d want=0/0", RVALID, COUNT);
      end
   endtask

   initial begin
      test_reset("por");
      test_single_word();
      test_discard();
      test_commit_discard();
      test_back_to_back();
      test_full();
      test_underflow_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
